// File: rtl/order_risk_gate.sv
// order_risk_gate: sequential front end for the combinational risk_check stage.
// Takes one new-order or cancel event at a time over valid/ready. It owns the
// accumulated and cancelled totals, commits them only when an event is
// accepted, and returns one accept/reject response for each event.
module order_risk_gate #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ord_valid,
    output logic             ord_ready,
    input  logic             ord_cancel,
    input  logic [W-1:0]     ord_amount,
    input  logic [W-1:0]     cfg_max,
    input  logic             pos_clear,
    output logic [W-1:0]     rc_accumulated,
    output logic [W-1:0]     rc_cancelled,
    output logic [W-1:0]     rc_amount,
    output logic [W-1:0]     rc_max,
    input  logic             rc_check,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_accept,
    output logic [CNT_W-1:0] reject_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_accum;
    logic [W-1:0]     r_cancelled;
    logic [W-1:0]     r_amount;
    logic             r_accept;
    logic             r_clear_pend;
    logic [CNT_W-1:0] r_reject_cnt;

    state_t           w_state_nxt;
    logic [W-1:0]     w_accum_nxt;
    logic [W-1:0]     w_cancelled_nxt;
    logic [W-1:0]     w_amount_nxt;
    logic             w_accept_nxt;
    logic             w_clear_pend_nxt;
    logic [CNT_W-1:0] w_reject_cnt_nxt;

    logic             w_take;
    logic [W-1:0]     w_headroom;
    logic [W:0]       w_sum;
    logic [W-1:0]     w_accum_sat;
    logic [CNT_W-1:0] w_reject_inc;

    assign w_take     = ord_valid && (r_state == S_IDLE);
    // The invariant cancelled <= accumulated keeps this difference from wrapping.
    assign w_headroom = r_accum - r_cancelled;
    assign w_sum      = {1'b0, r_accum} + {1'b0, r_amount};
    // Pinning the total at all-ones means risk_check never sees a wrapped value.
    assign w_accum_sat  = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
    assign w_reject_inc = (&r_reject_cnt) ? r_reject_cnt : r_reject_cnt + 1'b1;

    assign ord_ready      = (r_state == S_IDLE);
    assign resp_valid     = (r_state == S_RESP);
    assign resp_accept    = r_accept;
    assign rc_accumulated = r_accum;
    assign rc_cancelled   = r_cancelled;
    assign rc_amount      = r_amount;
    assign rc_max         = cfg_max;
    assign reject_cnt     = r_reject_cnt;

    // Next-state and datapath decisions for the IDLE -> CHECK/RESP -> IDLE flow.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        w_state_nxt      = r_state;
        w_accum_nxt      = r_accum;
        w_cancelled_nxt  = r_cancelled;
        w_amount_nxt     = r_amount;
        w_accept_nxt     = r_accept;
        w_clear_pend_nxt = r_clear_pend;
        w_reject_cnt_nxt = r_reject_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_amount_nxt     = ord_amount;
                    // A clear that arrives with an event waits until that event has committed.
                    w_clear_pend_nxt = pos_clear;
                    if (ord_cancel) begin
                        // A cancel never goes through risk_check; it is decided here.
                        if (ord_amount <= w_headroom) begin
                            w_cancelled_nxt = r_cancelled + ord_amount;
                            w_accept_nxt    = 1'b1;
                        end else begin
                            w_accept_nxt     = 1'b0;
                            w_reject_cnt_nxt = w_reject_inc;
                        end
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_CHECK;
                    end
                end else if (pos_clear) begin
                    w_accum_nxt     = '0;
                    w_cancelled_nxt = '0;
                end
            end

            S_CHECK: begin
                if (!rc_check) begin
                    w_accum_nxt  = w_accum_sat;
                    w_accept_nxt = 1'b1;
                end else begin
                    w_accept_nxt     = 1'b0;
                    w_reject_cnt_nxt = w_reject_inc;
                end
                if (pos_clear) begin
                    w_clear_pend_nxt = 1'b1;
                end
                w_state_nxt = S_RESP;
            end

            S_RESP: begin
                if (pos_clear) begin
                    w_clear_pend_nxt = 1'b1;
                end
                if (resp_ready) begin
                    // A deferred clear is applied as the response is consumed.
                    if (r_clear_pend || pos_clear) begin
                        w_accum_nxt     = '0;
                        w_cancelled_nxt = '0;
                    end
                    w_clear_pend_nxt = 1'b0;
                    w_state_nxt      = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any event in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_accum      <= '0;
            r_cancelled  <= '0;
            r_amount     <= '0;
            r_accept     <= 1'b0;
            r_clear_pend <= 1'b0;
            r_reject_cnt <= '0;
        end else begin
            // NOTE: non-blocking updates let every register see pre-edge values.
            r_state      <= w_state_nxt;
            r_accum      <= w_accum_nxt;
            r_cancelled  <= w_cancelled_nxt;
            r_amount     <= w_amount_nxt;
            r_accept     <= w_accept_nxt;
            r_clear_pend <= w_clear_pend_nxt;
            r_reject_cnt <= w_reject_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_order_risk_gate.sv
// Bench for order_risk_gate: directed events. Expected responses are queued as
// each event is issued and popped by a monitor whenever a response is consumed.
module tb_order_risk_gate;

    localparam int W     = 32;
    localparam int CNT_W = 16;
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    typedef struct {
        logic             accept;
        logic [W-1:0]     accum;
        logic [W-1:0]     canc;
        logic [CNT_W-1:0] rej;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             ord_valid;
    logic             ord_ready;
    logic             ord_cancel;
    logic [W-1:0]     ord_amount;
    logic [W-1:0]     cfg_max;
    logic             pos_clear;
    logic [W-1:0]     rc_accumulated;
    logic [W-1:0]     rc_cancelled;
    logic [W-1:0]     rc_amount;
    logic [W-1:0]     rc_max;
    logic             rc_check;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_accept;
    logic [CNT_W-1:0] reject_cnt;

    int   n_tests;
    int   n_fail;
    int   rc_mode;   // 0 = risk_check model, 1 = force pass, 2 = force fail
    exp_t sb[$];

    order_risk_gate #(.W(W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ord_valid      (ord_valid),
        .ord_ready      (ord_ready),
        .ord_cancel     (ord_cancel),
        .ord_amount     (ord_amount),
        .cfg_max        (cfg_max),
        .pos_clear      (pos_clear),
        .rc_accumulated (rc_accumulated),
        .rc_cancelled   (rc_cancelled),
        .rc_amount      (rc_amount),
        .rc_max         (rc_max),
        .rc_check       (rc_check),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_accept    (resp_accept),
        .reject_cnt     (reject_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural risk_check: fail when accumulated - cancelled + amount exceeds the limit.
    always_comb begin
        logic [W+1:0] need;
        need = {2'b00, rc_accumulated} - {2'b00, rc_cancelled} + {2'b00, rc_amount};
        if (rc_mode == 2)      rc_check = 1'b1;
        else if (rc_mode == 1) rc_check = 1'b0;
        else                   rc_check = (need > {2'b00, rc_max});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every consumed response against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_response", 64'(resp_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_accept", 64'(resp_accept), 64'(e.accept));
                check("resp_accum", 64'(rc_accumulated), 64'(e.accum));
                check("resp_cancelled", 64'(rc_cancelled), 64'(e.canc));
                check("resp_reject_cnt", 64'(reject_cnt), 64'(e.rej));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer an event and return #1 after the edge on which it was taken.
    task automatic take(input logic cancel, input logic [W-1:0] amt, input logic clr);
        int n;
        ord_valid  = 1'b1;
        ord_cancel = cancel;
        ord_amount = amt;
        pos_clear  = clr;
        n = 0;
        while (!ord_ready && n < 20) begin
            tick();
            n++;
        end
        check("take_timeout", 64'(n < 20), 64'd1);
        tick();
        ord_valid = 1'b0;
        pos_clear = 1'b0;
    endtask

    task automatic send(input logic cancel, input logic [W-1:0] amt, input exp_t e,
                        input int exp_lat, input logic clr_at_take, input logic clr_in_check);
        int lat;
        sb.push_back(e);
        take(cancel, amt, clr_at_take);
        if (clr_in_check) pos_clear = 1'b1;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            tick();
            pos_clear = 1'b0;
            lat++;
        end
        pos_clear = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!ord_ready && n < 20) begin
            tick();
            n++;
        end
        check("idle_timeout", 64'(n < 20), 64'd1);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rc_mode    = 0;
        rst_n      = 1'b0;
        ord_valid  = 1'b0;
        ord_cancel = 1'b0;
        ord_amount = '0;
        cfg_max    = 32'd100;
        pos_clear  = 1'b0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_ord_ready", 64'(ord_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_accept", 64'(resp_accept), 64'd0);
        check("rst_accum", 64'(rc_accumulated), 64'd0);
        check("rst_cancelled", 64'(rc_cancelled), 64'd0);
        check("rst_amount", 64'(rc_amount), 64'd0);
        check("rst_reject_cnt", 64'(reject_cnt), 64'd0);
        check("rc_max_mirror", 64'(rc_max), 64'd100);

        // 1: order 40 passes, response two cycles after acceptance
        send(1'b0, 32'd40, '{1'b1, 32'd40, 32'd0, 16'd0}, 2, 1'b0, 1'b0);
        wait_idle();
        send(1'b0, 32'd50, '{1'b1, 32'd90, 32'd0, 16'd0}, 2, 1'b0, 1'b0);
        wait_idle();

        // 2: order 20 from 90 exceeds the limit of 100
        send(1'b0, 32'd20, '{1'b0, 32'd90, 32'd0, 16'd1}, 2, 1'b0, 1'b0);
        wait_idle();

        // pos_clear in IDLE with no event zeroes totals on the next edge
        pos_clear = 1'b1;
        tick();
        pos_clear = 1'b0;
        check("idle_clear_accum", 64'(rc_accumulated), 64'd0);
        check("idle_clear_reject_kept", 64'(reject_cnt), 64'd1);

        // 3: accum 50, cancel 30 accepted, cancel 25 rejected, cancel 20 fits exactly
        send(1'b0, 32'd50, '{1'b1, 32'd50, 32'd0, 16'd1}, 2, 1'b0, 1'b0);
        wait_idle();
        send(1'b1, 32'd30, '{1'b1, 32'd50, 32'd30, 16'd1}, 1, 1'b0, 1'b0);
        wait_idle();
        send(1'b1, 32'd25, '{1'b0, 32'd50, 32'd30, 16'd2}, 1, 1'b0, 1'b0);
        wait_idle();
        send(1'b1, 32'd20, '{1'b1, 32'd50, 32'd50, 16'd2}, 1, 1'b0, 1'b0);
        wait_idle();

        // 4: response held for 5 cycles while another event is offered
        resp_ready = 1'b0;
        send(1'b0, 32'd10, '{1'b1, 32'd60, 32'd50, 16'd2}, 2, 1'b0, 1'b0);
        ord_valid  = 1'b1;
        ord_cancel = 1'b0;
        ord_amount = 32'd77;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_resp_valid", 64'(resp_valid), 64'd1);
            check("hold_resp_accept", 64'(resp_accept), 64'd1);
            check("hold_ord_ready", 64'(ord_ready), 64'd0);
            check("hold_amount", 64'(rc_amount), 64'd10);
        end
        ord_valid  = 1'b0;
        resp_ready = 1'b1;
        wait_idle();
        check("hold_accum_after", 64'(rc_accumulated), 64'd60);

        // 5: pos_clear during CHECK, order commits then totals clear on RESP exit
        send(1'b0, 32'd10, '{1'b1, 32'd70, 32'd50, 16'd2}, 2, 1'b0, 1'b1);
        wait_idle();
        check("pend_clear_accum", 64'(rc_accumulated), 64'd0);
        check("pend_clear_cancelled", 64'(rc_cancelled), 64'd0);

        // pos_clear coinciding with the IDLE handshake
        send(1'b0, 32'd5, '{1'b1, 32'd5, 32'd0, 16'd2}, 2, 1'b1, 1'b0);
        wait_idle();
        check("hs_clear_accum", 64'(rc_accumulated), 64'd0);

        // 6: saturation at all-ones, then reset during CHECK aborts the event
        cfg_max = ALL_ONES;
        send(1'b0, ALL_ONES - 32'd4, '{1'b1, ALL_ONES - 32'd4, 32'd0, 16'd2}, 2, 1'b0, 1'b0);
        wait_idle();
        rc_mode = 1;
        send(1'b0, 32'd10, '{1'b1, ALL_ONES, 32'd0, 16'd2}, 2, 1'b0, 1'b0);
        wait_idle();
        rc_mode = 0;
        check("sat_accum", 64'(rc_accumulated), 64'(ALL_ONES));

        take(1'b0, 32'd1, 1'b0);
        check("abort_in_check", 64'(ord_ready), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_resp", 64'(resp_valid), 64'd0);
        end
        check("abort_ord_ready", 64'(ord_ready), 64'd1);
        check("abort_accum", 64'(rc_accumulated), 64'd0);
        check("abort_cancelled", 64'(rc_cancelled), 64'd0);
        check("abort_amount", 64'(rc_amount), 64'd0);
        check("abort_reject_cnt", 64'(reject_cnt), 64'd0);

        repeat (3) tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
